// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RISC-V M-extension multiply/divide for the EX stage, one bit per cycle.
// The divider and ops 1xx exist only when EX_MULDIV_DIV_EN is defined; otherwise they finish with Result=0.
module ex_muldiv_unit #(
    parameter int NrOfBits = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                Start,
    input  logic [2:0]          Op,
    input  logic [NrOfBits-1:0] SrcA,
    input  logic [NrOfBits-1:0] SrcB,
    input  logic                Flush,
    output logic                Busy,
    output logic                Done,
    output logic                Stall,
    output logic [NrOfBits-1:0] Result
);
    localparam int CW = $clog2(NrOfBits);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         count;
    logic [2:0]            op_q;
    logic [NrOfBits-1:0]   a_q;
    logic [2*NrOfBits-1:0] acc;
    logic                  neg_q, neg_r;

    logic                  accept, is_div, div_ok, special, sign_a, sign_b, a_neg, b_neg;
    logic [NrOfBits-1:0]   mag_a, mag_b, rem, fix_res;
    logic [NrOfBits:0]     mul_sum;
    logic [2*NrOfBits-1:0] mul_next, div_next, acc_init, prod;

`ifdef EX_MULDIV_DIV_EN
    logic [NrOfBits:0] rem_sh, diff;
    // Restoring step: acc = {remainder, quotient/dividend}; borrow (diff msb) means keep the shifted remainder.
    assign rem_sh   = acc[2*NrOfBits-1:NrOfBits-1];
    assign diff     = rem_sh - {1'b0, a_q};
    assign div_next = {diff[NrOfBits] ? rem_sh[NrOfBits-1:0] : diff[NrOfBits-1:0], acc[NrOfBits-2:0], ~diff[NrOfBits]};
    assign div_ok   = 1'b1;
`else
    assign div_next = acc;
    assign div_ok   = 1'b0;
`endif

    assign accept  = state == IDLE && Start && !Flush;
    assign is_div  = Op[2];
    assign sign_a  = Op == 3'b001 || Op == 3'b010 || (is_div && !Op[0]);
    assign sign_b  = Op == 3'b001 || (is_div && !Op[0]);
    assign a_neg   = sign_a && SrcA[NrOfBits-1];
    assign b_neg   = sign_b && SrcB[NrOfBits-1];
    assign mag_a   = a_neg ? -SrcA : SrcA;
    assign mag_b   = b_neg ? -SrcB : SrcB;
    assign special = div_ok && is_div &&
                     (SrcB == '0 || (!Op[0] && SrcA == {1'b1, {(NrOfBits-1){1'b0}}} && SrcB == '1));
    // Special cases preload acc with the raw answer and skip CALC; FIX then passes it through un-negated.
    assign acc_init = special ? (SrcB == '0 ? {SrcA, {NrOfBits{1'b1}}} : {{NrOfBits{1'b0}}, SrcA})
                              : {{NrOfBits{1'b0}}, is_div ? mag_a : mag_b};

    assign mul_sum  = {1'b0, acc[2*NrOfBits-1:NrOfBits]} + (acc[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, acc[NrOfBits-1:1]};
    assign prod     = neg_q ? -acc : acc;
    assign rem      = neg_r ? -acc[2*NrOfBits-1:NrOfBits] : acc[2*NrOfBits-1:NrOfBits];
    assign fix_res  = op_q[2] ? (op_q[1] ? rem : prod[NrOfBits-1:0])
                              : (op_q[1:0] == 2'b00 ? prod[NrOfBits-1:0] : prod[2*NrOfBits-1:NrOfBits]);

    assign Busy  = state == CALC || state == FIX;
    assign Done  = state == DONE;
    assign Stall = accept || Busy;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            count  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            Result <= '0;
        end else if (ClockEnable) begin
            case (state)
                IDLE: if (accept) begin
                    op_q  <= Op;
                    a_q   <= is_div ? mag_b : mag_a;
                    acc   <= acc_init;
                    neg_q <= !special && (a_neg ^ b_neg);
                    neg_r <= !special && a_neg;
                    count <= CW'(NrOfBits - 1);
                    state <= (is_div && !div_ok) ? DONE : special ? FIX : CALC;
                    if (is_div && !div_ok) Result <= '0;
                end
                CALC: begin
                    acc   <= op_q[2] ? div_next : mul_next;
                    count <= count - CW'(1);
                    state <= Flush ? IDLE : count == '0 ? FIX : CALC;
                end
                FIX: begin
                    state <= Flush ? IDLE : DONE;
                    if (!Flush) Result <= fix_res;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vector table, corner-case sequences and randomized ops for ex_muldiv_unit.
// Honours EX_MULDIV_DIV_EN the same way the design does.
module tb_ex_muldiv_unit;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ClockEnable = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Op = '0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        Flush = 1'b0;
    logic        Busy, Done, Stall;
    logic [31:0] Result;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] MIN = 32'h8000_0000;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    ex_muldiv_unit #(.NrOfBits(32)) dut (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Start(Start), .Op(Op),
        .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush), .Busy(Busy), .Done(Done), .Stall(Stall), .Result(Result)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit / integer arithmetic from the M-extension rules.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
`ifndef EX_MULDIV_DIV_EN
        if (op[2]) return '0;
`endif
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : (a == MIN && b == 32'hFFFF_FFFF) ? MIN : 32'(ia / ib);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : (a == MIN && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef EX_MULDIV_DIV_EN
        if (op[2] && (b == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF))) return 2;
        return 34;
`else
        return op[2] ? 1 : 34;
`endif
    endfunction

    task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
`ifndef EX_MULDIV_DIV_EN
        if (op[2]) begin v.res = '0; v.lat = 1; end
`endif
        tbl.push_back(v);
    endtask

    // lat counts cycles after the accept edge until Done is seen; stalls counts Stall cycles before Done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int ce_at, input bit hold, output logic [31:0] res,
                          output int lat, output int stalls);
        @(negedge Clock);
        Op = op; SrcA = a; SrcB = b; Start = 1'b1;
        #1 check("stall_at_accept", 64'(Stall), 64'd1);
        lat = 0;
        stalls = 0;
        @(negedge Clock);
        if (!hold) Start = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            ClockEnable = !(ce_at > 0 && i >= ce_at && i < ce_at + 5);
            if (hold) begin SrcA = $urandom; SrcB = $urandom; end
            #1;
            if (Done) begin lat = i; break; end
            stalls += int'(Stall);
            @(negedge Clock);
        end
        ClockEnable = 1'b1;
        if (lat == 0) $display("FAIL timeout: op %0d never signalled Done", op);
        res = Result;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res, a, b;
        logic [2:0]  op;
        int          lat, stalls, seen;

        add(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        add(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        add(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
        add(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         34);
        add(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        add(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        add(3'd5, 32'd100,       32'd7,         32'd14,        34);
        add(3'd7, 32'd100,       32'd7,         32'd2,         34);
        add(3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF, 2);
        add(3'd7, 32'h1234,      32'd0,         32'h1234,      2);
        add(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        add(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);
        add(3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2);

        repeat (2) @(negedge Clock);
        #1;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_stall", 64'(Stall), 64'd0);
        check("reset_result", 64'(Result), 64'd0);
        @(negedge Clock);
        Reset = 1'b0;

        run_op(3'd0, 32'd7, 32'd6, 0, 1'b0, res, lat, stalls);
        check("mul7x6_result", 64'(res), 64'd42);
        check("mul7x6_latency", 64'(lat), 64'd34);
        check("mul7x6_stall_cycles", 64'(stalls), 64'd33);

        // Flush in the 10th CALC cycle.
        @(negedge Clock);
        Op = 3'd0; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (9) @(negedge Clock);
        Flush = 1'b1;
        @(negedge Clock);
        Flush = 1'b0;
        #1;
        check("flush_busy", 64'(Busy), 64'd0);
        check("flush_result_held", 64'(Result), 64'd42);
        seen = 0;
        repeat (40) begin @(negedge Clock); #1 seen += int'(Done); end
        check("flush_no_done", 64'(seen), 64'd0);

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, 1'b0, res, lat, stalls);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(tbl[i].res));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
        end

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(op, a, b, 0, 1'b0, res, lat, stalls);
            check($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), 64'(res), 64'(model(op, a, b)));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(model_lat(op, a, b)));
        end

        run_op(3'd0, 32'd7, 32'd6, 10, 1'b0, res, lat, stalls);
        check("ce_gap_result", 64'(res), 64'd42);
        check("ce_gap_latency", 64'(lat), 64'd39);

        // Start held (operands changing) through DONE must not re-accept or relatch.
        run_op(3'd0, 32'd3, 32'd5, 0, 1'b1, res, lat, stalls);
        check("held_start_result", 64'(res), 64'd15);
        check("held_start_latency", 64'(lat), 64'd34);
        @(negedge Clock);
        Start = 1'b0;
        #1;
        check("held_start_no_reaccept", 64'({Busy, Done}), 64'd0);

        @(negedge Clock);
        Op = 3'd0; SrcA = 32'd3; SrcB = 32'd5; Start = 1'b1; Flush = 1'b1;
        #1 check("start_flush_stall", 64'(Stall), 64'd0);
        @(negedge Clock);
        Start = 1'b0; Flush = 1'b0;
        #1 check("start_flush_no_accept", 64'({Busy, Done}), 64'd0);

        @(negedge Clock);
        Op = 3'd1; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("midreset_busy", 64'(Busy), 64'd0);
        check("midreset_done", 64'(Done), 64'd0);
        check("midreset_stall", 64'(Stall), 64'd0);
        check("midreset_result", 64'(Result), 64'd0);
        @(negedge Clock);
        Reset = 1'b0;
        seen = 0;
        repeat (40) begin @(negedge Clock); #1 seen += int'(Done); end
        check("midreset_no_done", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
